// File: rtl/prog_clock_divider_pkg.sv
// -----------------------------------------------------------------------------
// prog_clock_divider_pkg
// Shared constants for the programmable clock divider:
//   CLK_INPUT_HZ         - frequency of the single input clock (100 MHz)
//   CLK_DEFAULT_CHANNELS - default number of divider channels
//   CLK_DEFAULT_WIDTH    - default width of half-period counter / divisor
//   CLK_DEFAULT_HALF     - half-period loaded at reset (10 kHz output)
//   half_for_freq()      - helper: half-period for a requested output rate
// -----------------------------------------------------------------------------
package prog_clock_divider_pkg;

   localparam int CLK_INPUT_HZ         = 100_000_000;
   localparam int CLK_DEFAULT_CHANNELS = 2;
   localparam int CLK_DEFAULT_WIDTH    = 16;
   localparam int CLK_DEFAULT_HALF     = 5000;

   // Output period is two half-periods, so divide by twice the target rate.
   function automatic int half_for_freq(input int freq_hz);
      return CLK_INPUT_HZ / (2 * freq_hz);
   endfunction

endpackage

// File: rtl/clock_div_channel.sv
// -----------------------------------------------------------------------------
// clock_div_channel
// One independent divider channel. Produces a 50% duty clock with a period of
// 2*H input cycles, where H is the active half-period. New divisors are staged
// while running and take effect only at a half-period boundary, so the output
// never produces a truncated or stretched phase mid-way.
// Ports:
//   clk_i         - input clock, rising edge
//   rst_ni        - synchronous active-low reset
//   enable_i      - run enable
//   load_i        - single-cycle load strobe for half_period_i
//   half_period_i - divisor value (half-period in input cycles)
//   clock_o       - divided clock (registered)
//   tick_o        - one-cycle pulse on the 0->1 transition of clock_o
//   pending_o     - a staged divisor awaits the next boundary
//   load_error_o  - one-cycle pulse when a zero divisor load is rejected
// -----------------------------------------------------------------------------
module clock_div_channel
   import prog_clock_divider_pkg::*;
#(
   parameter int WIDTH        = CLK_DEFAULT_WIDTH,
   parameter int DEFAULT_HALF = CLK_DEFAULT_HALF
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             enable_i,
   input  logic             load_i,
   input  logic [WIDTH-1:0] half_period_i,
   output logic             clock_o,
   output logic             tick_o,
   output logic             pending_o,
   output logic             load_error_o
);

   localparam logic [WIDTH-1:0] RESET_HALF = WIDTH'(DEFAULT_HALF);
   localparam logic [WIDTH-1:0] ONE        = WIDTH'(1);

   logic [WIDTH-1:0] count_q,  count_d;
   logic [WIDTH-1:0] half_q,   half_d;
   logic [WIDTH-1:0] staged_q, staged_d;
   logic             clock_q,      clock_d;
   logic             tick_q,       tick_d;
   logic             pending_q,    pending_d;
   logic             load_error_q, load_error_d;

   logic load_valid;
   logic boundary;

   always_comb begin
      load_valid   = load_i && (half_period_i != '0);
      // H is never zero (zero loads are rejected), so H-1 cannot wrap.
      boundary     = (count_q == (half_q - ONE));

      count_d      = count_q;
      half_d       = half_q;
      staged_d     = staged_q;
      clock_d      = clock_q;
      tick_d       = 1'b0;
      pending_d    = pending_q;
      load_error_d = load_i && (half_period_i == '0);

      if (enable_i) begin
         if (boundary) begin
            count_d = '0;
            clock_d = ~clock_q;
            tick_d  = ~clock_q;    // only on the rising transition
            if (pending_q) begin
               half_d    = staged_q;
               pending_d = 1'b0;
            end
         end else begin
            count_d = count_q + ONE;
         end
         // A load coinciding with a boundary is staged after the old staged
         // value has been consumed above, so it lands at the next boundary.
         if (load_valid) begin
            staged_d  = half_period_i;
            pending_d = 1'b1;
         end
      end else begin
         // Idle: output parked low, counter cleared so a restart yields a
         // full first half-period.
         count_d = '0;
         clock_d = 1'b0;
         if (load_valid) begin
            half_d    = half_period_i;
            staged_d  = half_period_i;
            pending_d = 1'b0;
         end else if (pending_q) begin
            half_d    = staged_q;
            pending_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         count_q      <= '0;
         half_q       <= RESET_HALF;
         staged_q     <= RESET_HALF;
         clock_q      <= 1'b0;
         tick_q       <= 1'b0;
         pending_q    <= 1'b0;
         load_error_q <= 1'b0;
      end else begin
         count_q      <= count_d;
         half_q       <= half_d;
         staged_q     <= staged_d;
         clock_q      <= clock_d;
         tick_q       <= tick_d;
         pending_q    <= pending_d;
         load_error_q <= load_error_d;
      end
   end

   assign clock_o      = clock_q;
   assign tick_o       = tick_q;
   assign pending_o    = pending_q;
   assign load_error_o = load_error_q;

endmodule

// File: rtl/prog_clock_divider.sv
// -----------------------------------------------------------------------------
// prog_clock_divider
// Bank of CHANNELS independent programmable clock dividers sharing one divisor
// input bus. Each load bit selects which channels capture half_period_in.
// All outputs come straight from registers inside the channels.
// Ports:
//   Clock_100MHz   - sole input clock, rising edge
//   Reset_n        - synchronous active-low reset
//   enable         - per-channel run enable
//   half_period_in - shared divisor value (half-period in input cycles)
//   load           - per-channel load strobe
//   clock_out      - divided clocks
//   tick           - per-channel pulse on each clock_out rising transition
//   pending        - per-channel staged-divisor flag
//   load_error     - per-channel pulse on a rejected zero load
// -----------------------------------------------------------------------------
module prog_clock_divider
   import prog_clock_divider_pkg::*;
#(
   parameter int CHANNELS     = CLK_DEFAULT_CHANNELS,
   parameter int WIDTH        = CLK_DEFAULT_WIDTH,
   parameter int DEFAULT_HALF = CLK_DEFAULT_HALF
) (
   input  logic                Clock_100MHz,
   input  logic                Reset_n,
   input  logic [CHANNELS-1:0] enable,
   input  logic [WIDTH-1:0]    half_period_in,
   input  logic [CHANNELS-1:0] load,
   output logic [CHANNELS-1:0] clock_out,
   output logic [CHANNELS-1:0] tick,
   output logic [CHANNELS-1:0] pending,
   output logic [CHANNELS-1:0] load_error
);

   generate
      for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_channel
         clock_div_channel #(
            .WIDTH        (WIDTH),
            .DEFAULT_HALF (DEFAULT_HALF)
         ) u_channel (
            .clk_i         (Clock_100MHz),
            .rst_ni        (Reset_n),
            .enable_i      (enable[gi]),
            .load_i        (load[gi]),
            .half_period_i (half_period_in),
            .clock_o       (clock_out[gi]),
            .tick_o        (tick[gi]),
            .pending_o     (pending[gi]),
            .load_error_o  (load_error[gi])
         );
      end
   endgenerate

endmodule

// File: tb/tb_prog_clock_divider.sv
module tb_prog_clock_divider;

   localparam int CH = 2;
   localparam int W  = 16;
   localparam int DH = 5000;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [CH-1:0] en, ld;
   logic [W-1:0]  hp;
   logic [CH-1:0] co, tk, pd, le;

   always #5 clk = ~clk;

   prog_clock_divider #(.CHANNELS(CH), .WIDTH(W), .DEFAULT_HALF(DH)) dut (
      .Clock_100MHz   (clk),
      .Reset_n        (rst_n),
      .enable         (en),
      .half_period_in (hp),
      .load           (ld),
      .clock_out      (co),
      .tick           (tk),
      .pending        (pd),
      .load_error     (le)
   );

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   // Reference model: time-stamp based. Each channel remembers the absolute
   // edge number at which its next half-period ends.
   bit m_level[CH], m_tick[CH], m_pend[CH], m_lerr[CH];
   int m_h[CH], m_s[CH], m_next[CH];

   task automatic check(input string tag, input logic [CH-1:0] obs, input logic [CH-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s cycle=%0d observed=%b expected=%b", tag, cyc, obs, exp);
      end
   endtask

   task automatic model_edge();
      for (int c = 0; c < CH; c++) begin
         if (!rst_n) begin
            m_level[c] = 0; m_tick[c] = 0; m_pend[c] = 0; m_lerr[c] = 0;
            m_h[c] = DH; m_s[c] = DH; m_next[c] = cyc + DH;
         end else begin
            m_lerr[c] = ld[c] && (hp == 0);
            if (en[c]) begin
               m_tick[c] = 0;
               if (cyc == m_next[c]) begin
                  m_level[c] = !m_level[c];
                  m_tick[c]  = m_level[c];
                  if (m_pend[c]) begin
                     m_h[c] = m_s[c];
                     m_pend[c] = 0;
                  end
                  m_next[c] = cyc + m_h[c];
               end
               if (ld[c] && hp != 0) begin
                  m_s[c] = int'(hp);
                  m_pend[c] = 1;
               end
            end else begin
               m_level[c] = 0; m_tick[c] = 0;
               if (ld[c] && hp != 0) begin
                  m_h[c] = int'(hp);
                  m_pend[c] = 0;
               end else if (m_pend[c]) begin
                  m_h[c] = m_s[c];
                  m_pend[c] = 0;
               end
               m_next[c] = cyc + m_h[c];
            end
         end
      end
   endtask

   task automatic step();
      logic [CH-1:0] e_co, e_tk, e_pd, e_le;
      @(posedge clk);
      cyc++;
      model_edge();
      #1;
      for (int c = 0; c < CH; c++) begin
         e_co[c] = m_level[c]; e_tk[c] = m_tick[c];
         e_pd[c] = m_pend[c];  e_le[c] = m_lerr[c];
      end
      check("model_clock_out", co, e_co);
      check("model_tick", tk, e_tk);
      check("model_pending", pd, e_pd);
      check("model_load_error", le, e_le);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      int guard;
      rst_n = 1'b0; en = '0; ld = '0; hp = '0;
      run(3);
      $display("reset applied: clock_out=%b tick=%b pending=%b load_error=%b", co, tk, pd, le);
      check("reset_clock_out", co, 2'b00);
      check("reset_tick", tk, 2'b00);
      check("reset_pending", pd, 2'b00);
      check("reset_load_error", le, 2'b00);

      // Default divisor from reset, both channels running.
      rst_n = 1'b1; en = 2'b11;
      run(4999);
      check("pre_first_rise", co, 2'b00);
      run(1);
      $display("edge 5000 after reset: clock_out=%b tick=%b", co, tk);
      check("first_rise", co, 2'b11);
      check("first_tick", tk, 2'b11);
      run(1);
      check("tick_one_cycle", tk, 2'b00);
      run(4998);
      check("high_half", co, 2'b11);
      run(1);
      check("first_fall", co, 2'b00);
      run(4999);
      check("no_tick_before_period", tk, 2'b00);
      run(1);
      $display("edge 15000 after reset: tick=%b", tk);
      check("tick_period_10000", tk, 2'b11);

      // Stage a new divisor mid-period on channel 0.
      rst_n = 1'b0; run(1); rst_n = 1'b1;
      run(1999);
      ld = 2'b01; hp = 16'd3; run(1); ld = 2'b00;
      $display("load 3 on ch0: pending=%b", pd);
      check("pending_set", pd, 2'b01);
      run(2999);
      check("pending_held", pd, 2'b01);
      run(1);
      check("boundary_applies", pd, 2'b00);
      check("boundary_rise", co, 2'b11);
      run(3);
      check("ch0_period6_fall", co, 2'b10);
      run(3);
      check("ch0_period6_rise", co, 2'b11);

      // Zero load is rejected.
      ld = 2'b01; hp = 16'd0; run(1); ld = 2'b00;
      $display("zero load on ch0: load_error=%b pending=%b", le, pd);
      check("zero_load_error", le, 2'b01);
      check("zero_load_pending", pd, 2'b00);
      run(1);
      check("zero_load_error_pulse", le, 2'b00);
      run(12);

      // Direct load of 1 while disabled, then enable channel 1.
      en = 2'b01; ld = 2'b10; hp = 16'd1; run(1); ld = 2'b00;
      check("disabled_load_pending", pd & 2'b10, 2'b00);
      check("disabled_clock_low", co & 2'b10, 2'b00);
      en = 2'b11; run(1);
      $display("ch1 enabled with H=1: clock_out=%b", co);
      check("h1_rise_after_1", co & 2'b10, 2'b10);
      run(1);
      check("h1_fall", co & 2'b10, 2'b00);
      run(1);
      check("h1_rise_again", co & 2'b10, 2'b10);

      // Drop enable on channel 0 while its clock is high.
      guard = 0;
      while (co[0] !== 1'b1 && guard < 20) begin
         run(1);
         guard++;
      end
      check("wait_ch0_high", co & 2'b01, 2'b01);
      en = 2'b10; run(1);
      check("disable_forces_low", co & 2'b01, 2'b00);
      run(2);
      en = 2'b11; run(2);
      check("reenable_not_yet", co & 2'b01, 2'b00);
      run(1);
      $display("ch0 re-enabled: clock_out=%b", co);
      check("reenable_rise_H", co & 2'b01, 2'b01);

      // Reset with a staged value outstanding.
      ld = 2'b01; hp = 16'd7; run(1); ld = 2'b00;
      check("stage_before_reset", pd & 2'b01, 2'b01);
      run(1);
      rst_n = 1'b0; ld = 2'b11; hp = 16'd9; run(1);
      $display("mid-period reset: clock_out=%b tick=%b pending=%b load_error=%b", co, tk, pd, le);
      check("reset_mid_clock", co, 2'b00);
      check("reset_mid_pending", pd, 2'b00);
      check("reset_mid_tick", tk, 2'b00);
      check("reset_mid_error", le, 2'b00);
      rst_n = 1'b1; ld = 2'b00;
      run(4999);
      check("reset_H_restored_pre", co, 2'b00);
      run(1);
      check("reset_H_restored_rise", co, 2'b11);

      // Randomized traffic against the model.
      en = 2'b00; ld = 2'b11; hp = 16'd2; run(1);
      en = 2'b11; ld = 2'b00;
      for (int i = 0; i < 4000; i++) begin
         rst_n = ($urandom_range(0, 799) != 0);
         if ($urandom_range(0, 19) == 0) en = CH'($urandom);
         ld = ($urandom_range(0, 5) == 0) ? CH'($urandom) : '0;
         hp = W'($urandom_range(0, 6));
         if (!rst_n) ld = 2'b00;
         step();
         if (!rst_n) begin
            rst_n = 1'b1; en = 2'b00; ld = 2'b11; hp = W'($urandom_range(1, 5));
            step();
            en = 2'b11; ld = 2'b00;
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout cycle=%0d observed=running required=finished", cyc);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/prog_clock_divider.md
PROG_CLOCK_DIVIDER -- requirements
Module: prog_clock_divider

Interface
REQ-001 Parameter: CHANNELS, 2, number of independent divider channels.
REQ-002 Parameter: WIDTH, 16, width of half-period counter and divisor.
REQ-003 Parameter: DEFAULT_HALF, 5000, reset half-period in input clocks (10 kHz from 100 MHz).
REQ-004 Port: Clock_100MHz  input  1  sole clock; all logic on rising edge.
REQ-005 Port: Reset_n  input  1  synchronous, active-low reset.
REQ-006 Port: enable  input  CHANNELS  per-channel run enable.
REQ-007 Port: half_period_in  input  WIDTH  divisor value, shared by all channels.
REQ-008 Port: load  input  CHANNELS  per-channel single-cycle load strobe for half_period_in.
REQ-009 Port: clock_out  output  CHANNELS  divided clocks, registered.
REQ-010 Port: tick  output  CHANNELS  one-cycle pulse, high during the first input cycle that clock_out is high.
REQ-011 Port: pending  output  CHANNELS  high while a staged divisor awaits application.
REQ-012 Port: load_error  output  CHANNELS  one-cycle pulse when a load of zero is rejected.

Function
REQ-013 Each channel SHALL hold active half-period H, staged value S, counter C (WIDTH bits); channels fully independent.
REQ-014 Enabled channel: C==H-1 SHALL toggle clock_out and clear C (boundary); else C increments by 1.
REQ-015 Output period SHALL be 2*H input cycles, 50% duty; H=1 yields Clock_100MHz/2.
REQ-016 tick SHALL assert only on boundaries where clock_out goes 0->1, registered with clock_out.
REQ-017 load with half_period_in!=0 on enabled channel SHALL write S and set pending; a later load before application overwrites S (last wins).
REQ-018 At a boundary with pending=1, H SHALL take S and pending SHALL clear; the new H governs the next half-period.
REQ-019 load in the same cycle as a boundary SHALL apply any previous S at that boundary and stage the new value, applied at the following boundary.
REQ-020 load with half_period_in==0 SHALL be ignored (H, S, pending unchanged) and pulse load_error for one cycle.
REQ-021 Disabled channel: next edge SHALL force C=0, clock_out=0, tick=0; state held while disabled.
REQ-022 Nonzero load on disabled channel SHALL write H directly next edge; pending stays 0; staged S, if any, applied to H on the cycle enable is low.
REQ-023 After enable rises, first clock_out rise SHALL occur H cycles later, then every 2*H cycles.
REQ-024 Multiple load bits set SHALL load all selected channels with the same value.

Reset
REQ-025 Reset_n low at a rising edge SHALL set clock_out=0, tick=0, pending=0, load_error=0, C=0, H=S=DEFAULT_HALF on all channels.
REQ-026 Reset mid-period SHALL discard any staged value; reset overrides load and enable in the same cycle.

Structure
REQ-027 A shared package SHALL hold DEFAULT_HALF, default WIDTH/CHANNELS and the 100 MHz input-clock constant.
REQ-028 One sub-module, clock_div_channel (single channel), SHALL be instantiated CHANNELS times via generate.
REQ-029 No combinational path from any input to any output.

Verification
REQ-030 Reset, enable=2'b11, no load -> first clock_out rise at cycle 5000, tick every 10000 cycles, 50% duty.
REQ-031 load[0] with 3 at cycle 2000 of a 5000 half-period -> pending[0]=1 until cycle 5000 boundary, then period 6, channel 1 unaffected.
REQ-032 load value 1 while disabled, then enable -> clock_out toggles every cycle, rise after 1 cycle, pending never set.
REQ-033 load value 0 -> load_error pulses one cycle, period unchanged, pending unchanged.
REQ-034 enable drop with clock_out high -> clock_out=0 next cycle; re-enable -> rise H cycles later.
REQ-035 Reset_n low mid-period with pending=1 -> next cycle all outputs 0, H back to 5000.
